sprite_ram_dma: RTL
===================

// Module: sprite_ram_dma
// PURPOSE
//  Bus-master writer for the sprite attribute RAM (2K x 8, mainboard dual-port). On each frame start it copies a
//  sprite list from CPU work RAM into sprite RAM, one 4-byte record per sprite. The sprite layer reads that RAM.
//  Record layout: +0 INDX, +1 HPOS, +2 XDAT, +3 VPOS.
//  It stops early when a record's INDX byte equals END_MARK. It then fills the remaining records with HIDE_VPOS,
//  so stale sprites never reach the line buffers. Sits between the Z80 bus arbiter and sprite RAM write port B.
// PARAMETERS
//  SRC_BASE    16'hE000  work-RAM byte address of record 0
//  DST_BASE    11'h000   sprite-RAM byte address of record 0
//  ENTRIES     128       records per frame (1..512); copy length = ENTRIES*4 bytes
//  RD_LATENCY  1         cycles from src_rd to valid src_data (1..3)
//  END_MARK    8'hFF     INDX value terminating the list
//  HIDE_VPOS   8'hF8     VPOS written to fill records (off-screen)
// PORTS
//  master_clk  in   1   system clock; all state on rising edge
//  nRESET      in   1   asynchronous, active-low reset
//  start       in   1   frame trigger (CPU_RAM_SYNC); rising edge arms a transfer
//  dma_req     out  1   bus request to Z80 arbiter
//  dma_gnt     in   1   bus grant; may drop at any cycle
//  src_addr    out  16  work-RAM read address
//  src_rd      out  1   one-cycle read strobe
//  src_data    in   8   read data, valid RD_LATENCY cycles after src_rd
//  dst_addr    out  11  sprite-RAM write address
//  dst_data    out  8   sprite-RAM write data
//  dst_we      out  1   one-cycle write strobe, active-high
//  busy        out  1   high from arm until DONE
//  done        out  1   one-cycle pulse at completion
//  count       out  10  records copied before END_MARK; held until next arm
// BEHAVIOUR
//  Reset (async, nRESET=0): state IDLE; dma_req, src_rd, dst_we, busy and done = 0; addresses, dst_data and count = 0.
//  Start detection: register start. Arm on 0->1 only in IDLE. Edges while busy are ignored, not queued.
//  FSM:
//   IDLE: on edge -> REQ; busy=1, byte ptr b=0, count=0, fill=0.
//   REQ: dma_req=1; when dma_gnt=1 -> RD.
//   RD:  if fill=0, src_rd=1 and src_addr=SRC_BASE+b -> WT; if fill=1, go straight to WR.
//   WT:  wait RD_LATENCY cycles, then latch src_data -> WR.
//   WR:  dst_we=1, dst_addr=DST_BASE+b[10:0].
//        Data: latched byte; in fill mode, HIDE_VPOS when b[1:0]=3, else 8'h00.
//        End check: if b[1:0]=0, fill=0 and byte==END_MARK -> set fill=1 and write 8'h00 instead.
//        After each write: b++. A completed record in copy mode increments count.
//        If b==ENTRIES*4 -> DONE, else -> RD.
//   DONE: done=1 for one cycle; dma_req=0, busy=0 -> IDLE.
//  Throughput: RD_LATENCY+2 cycles per copied byte; 2 cycles per fill byte.
//  Grant loss: if dma_gnt=0 in RD or WR, no strobe is issued and the FSM returns to REQ with b held.
//   A read already in flight (WT) completes and its data is held.
//   The transfer resumes at the same b with no byte lost or duplicated.
//  Strobe rule: src_rd and dst_we are only ever asserted while dma_gnt=1.
//  Address arithmetic: source is 16-bit wrap-around; destination is modulo 2048.
//  Reset mid-transfer aborts at once; sprite RAM is left partially written.
//  An END_MARK byte is never written; its slot gets 8'h00.
// STRUCTURE
//  Shared package: record offsets (REC_INDX=0, REC_HPOS=1, REC_XDAT=2, REC_VPOS=3), REC_BYTES=4, and the FSM
//  state encoding, also used by the sprite layer.
//  One sub-module: sprite_dma_edge (start synchroniser/edge detector, 2 flops).
//  FSM, byte counter and latency counter stay inline.
// TESTING
//  1 ENTRIES=4, work RAM = bytes 01..10 with no marker -> 16 writes, dst 000..00F = 01..10; count=4; done after 48+ cycles.
//  2 Record 2 INDX=FF -> dst 000..007 copied; 008,009,00A = 00; 00B = F8; 00C..00E = 00; 00F = F8; count=2.
//  3 dma_gnt dropped for 5 cycles mid-WT at b=6 -> no strobes while low; dst_data sequence identical to test 1.
//  4 Second start edge while busy=1 -> ignored; exactly one done pulse; busy low after DONE.
//  5 nRESET asserted at b=9 -> outputs 0 immediately; next start edge copies from b=0.
//  6 RD_LATENCY=3, SRC_BASE=FFFE -> src_addr wraps FFFE,FFFF,0000; 5 cycles per byte.

Source files
------------

// File: rtl/sprite_ram_dma_pkg.sv
// Shared definitions for the sprite RAM DMA and the sprite layer that reads its output:
// record byte offsets and the DMA FSM state encoding.
package sprite_ram_dma_pkg;

  localparam int unsigned REC_INDX  = 0;
  localparam int unsigned REC_HPOS  = 1;
  localparam int unsigned REC_XDAT  = 2;
  localparam int unsigned REC_VPOS  = 3;
  localparam int unsigned REC_BYTES = 4;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRd,
    StWt,
    StWr,
    StDone
  } dma_state_e;

endpackage

// File: rtl/sprite_dma_edge.sv
// Start-trigger register pair: samples the frame trigger and flags a 0->1 transition
// for exactly one clock.
module sprite_dma_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic rise_o
);

  logic start_q, start_d;
  logic prev_q, prev_d;

  always_comb begin
    start_d = start_i;
    prev_d  = start_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_o = start_q & ~prev_q;

endmodule

// File: rtl/sprite_ram_dma.sv
// Frame-start DMA from CPU work RAM into sprite attribute RAM, one 4-byte record per sprite.
// After an END_MARK index the remaining records are filled so they land off-screen.
module sprite_ram_dma
  import sprite_ram_dma_pkg::*;
#(
  parameter logic [15:0] SRC_BASE   = 16'hE000,
  parameter logic [10:0] DST_BASE   = 11'h000,
  parameter int unsigned ENTRIES    = 128,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [7:0]  END_MARK   = 8'hFF,
  parameter logic [7:0]  HIDE_VPOS  = 8'hF8
) (
  input  logic        master_clk,
  input  logic        nRESET,
  input  logic        start,
  output logic        dma_req,
  input  logic        dma_gnt,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  output logic [10:0] dst_addr,
  output logic [7:0]  dst_data,
  output logic        dst_we,
  output logic        busy,
  output logic        done,
  output logic [9:0]  count
);

  localparam int unsigned TotalBytes = ENTRIES * REC_BYTES;
  localparam logic [11:0] LastByte   = 12'(TotalBytes - 1);
  localparam logic [1:0]  LatMax     = 2'(RD_LATENCY);
  localparam logic [1:0]  OffIndx    = 2'(REC_INDX);
  localparam logic [1:0]  OffVpos    = 2'(REC_VPOS);

  dma_state_e  state_q, state_d;
  logic [11:0] b_q, b_d;
  logic [9:0]  count_q, count_d;
  logic        fill_q, fill_d;
  logic        have_q, have_d;  // latched byte survives a grant loss in WR
  logic [1:0]  lat_q, lat_d;
  logic [7:0]  data_q, data_d;

  logic       rise;
  logic [1:0] rec_off;
  logic       is_end;
  logic [7:0] wr_byte;

  sprite_dma_edge u_edge (
    .clk_i   (master_clk),
    .rst_ni  (nRESET),
    .start_i (start),
    .rise_o  (rise)
  );

  always_comb begin
    rec_off = b_q[1:0];
    is_end  = !fill_q && (rec_off == OffIndx) && (data_q == END_MARK);
    if (fill_q) begin
      wr_byte = (rec_off == OffVpos) ? HIDE_VPOS : 8'h00;
    end else if (is_end) begin
      wr_byte = 8'h00;
    end else begin
      wr_byte = data_q;
    end
  end

  always_ff @(posedge master_clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= StIdle;
      b_q     <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
      have_q  <= 1'b0;
      lat_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      have_q  <= have_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    count_d = count_q;
    fill_d  = fill_q;
    have_d  = have_q;
    lat_d   = lat_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StReq;
          b_d     = '0;
          count_d = '0;
          fill_d  = 1'b0;
          have_d  = 1'b0;
        end
      end
      StReq: begin
        if (dma_gnt) state_d = StRd;
      end
      StRd: begin
        if (!dma_gnt) begin
          state_d = StReq;
        end else if (fill_q || have_q) begin
          state_d = StWr;
        end else begin
          state_d = StWt;
          lat_d   = 2'd1;
        end
      end
      StWt: begin
        // An issued read always completes, grant or not.
        if (lat_q == LatMax) begin
          data_d  = src_data;
          have_d  = 1'b1;
          state_d = StWr;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StWr: begin
        if (!dma_gnt) begin
          state_d = StReq;
        end else begin
          have_d = 1'b0;
          if (is_end) fill_d = 1'b1;
          if (!fill_q && (rec_off == OffVpos)) count_d = count_q + 10'd1;
          b_d     = b_q + 12'd1;
          state_d = (b_q == LastByte) ? StDone : StRd;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q == StReq) || (state_q == StRd) || (state_q == StWt) ||
               (state_q == StWr);
    dma_req  = busy;
    done     = (state_q == StDone);
    src_rd   = (state_q == StRd) && dma_gnt && !fill_q && !have_q;
    dst_we   = (state_q == StWr) && dma_gnt;
    src_addr = busy ? (SRC_BASE + {4'b0000, b_q}) : 16'h0000;
    dst_addr = busy ? (DST_BASE + b_q[10:0]) : 11'h000;
    dst_data = (state_q == StWr) ? wr_byte : 8'h00;
    count    = count_q;
  end

endmodule
